i2s_tx: RTL and testbench

Parametrised I2S/left-justified stereo transmitter: derives the bit clock (SCLK) and word clock (LRCLK) from the master clock, accepts stereo sample pairs over a valid/ready handshake, and serialises them MSB-first. Sits between the audio sample source and the DAC pins, replacing the fixed-ratio clock generator with a complete data path. It adds configurable ratio, slot/data width, framing mode, sample buffering and underrun reporting.

---
 rtl/i2s_tx.sv | 163 ++++++++++++++++
 tb/tb_i2s_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: I2S / left-justified stereo transmitter.
// Ports:
//   clk_i2s, reset              master clock, async active-high reset
//   s_left, s_right             stereo sample pair (two's complement)
//   s_valid, s_ready            sample pair handshake
//   underrun                    pulse when a frame starts with no pair buffered
//   tx_mclk, tx_sclk            master clock copy, bit clock
//   tx_lrclk, tx_data           word clock (0 = left), serial data MSB-first
module i2s_tx #(
   parameter int MCLK_SCLK_RATIO = 4,
   parameter int SLOT_WIDTH      = 32,
   parameter int DATA_WIDTH      = 24,
   parameter bit LEFT_JUSTIFIED  = 1'b0
) (
   input  logic                  clk_i2s,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] s_left,
   input  logic [DATA_WIDTH-1:0] s_right,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic                  underrun,
   output logic                  tx_mclk,
   output logic                  tx_sclk,
   output logic                  tx_lrclk,
   output logic                  tx_data
);

   localparam int HALF  = MCLK_SCLK_RATIO / 2;
   localparam int DVW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int FRAME = 2 * SLOT_WIDTH;
   localparam int PW    = $clog2(FRAME);

   localparam logic [DVW-1:0] DIV_TC   = DVW'(HALF - 1);
   localparam logic [PW-1:0]  POS_LAST = PW'(FRAME - 1);
   localparam logic [PW-1:0]  SLOT_W   = PW'(SLOT_WIDTH);

   localparam logic [DATA_WIDTH-1:0] MSB_MASK =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic [DVW-1:0]        r_div;
   logic                  r_sclk;
   logic [PW-1:0]         r_pos;
   logic                  r_data;
   logic                  r_lrclk;
   logic                  r_underrun;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_hold_l;
   logic [DATA_WIDTH-1:0] r_hold_r;
   logic [DATA_WIDTH-1:0] r_frame_l;
   logic [DATA_WIDTH-1:0] r_frame_r;

   logic                  w_tc;
   logic                  w_fall;
   logic                  w_load;
   logic                  w_accept;
   logic [PW-1:0]         w_pos_nxt;
   logic [PW-1:0]         w_pos_nxt1;
   logic                  w_slot_nxt;
   logic [PW-1:0]         w_k_nxt;
   logic [DATA_WIDTH-1:0] w_src_l;
   logic [DATA_WIDTH-1:0] w_src_r;
   logic [DATA_WIDTH-1:0] w_src;
   logic                  w_data_nxt;
   logic                  w_lrclk_nxt;

   assign w_tc     = (r_div == DIV_TC);
   assign w_fall   = w_tc & r_sclk;
   assign w_load   = w_fall & (r_pos == POS_LAST);
   assign w_accept = s_valid & ~r_full;

   always_comb begin
      w_pos_nxt   = '0;
      w_pos_nxt1  = '0;
      w_slot_nxt  = 1'b0;
      w_k_nxt     = '0;
      w_src_l     = r_frame_l;
      w_src_r     = r_frame_r;
      w_src       = '0;
      w_data_nxt  = 1'b0;
      w_lrclk_nxt = 1'b0;

      w_pos_nxt  = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
      w_pos_nxt1 = (w_pos_nxt == POS_LAST) ? '0 : w_pos_nxt + 1'b1;
      w_slot_nxt = (w_pos_nxt >= SLOT_W);
      w_k_nxt    = w_slot_nxt ? w_pos_nxt - SLOT_W : w_pos_nxt;

      // On the load edge the outgoing bit comes from the frame being
      // loaded, not from the registers still holding the old frame.
      if (w_load) begin
         w_src_l = r_full ? r_hold_l : '0;
         w_src_r = r_full ? r_hold_r : '0;
      end
      w_src = w_slot_nxt ? w_src_r : w_src_l;

      // Mask walks right from the MSB; k >= DATA_WIDTH shifts it out,
      // which yields the zero padding at the end of each slot.
      w_data_nxt = |(w_src & (MSB_MASK >> w_k_nxt));

      // I2S: LRCLK switches one bit ahead of the slot's first data bit.
      w_lrclk_nxt = LEFT_JUSTIFIED ? w_slot_nxt : (w_pos_nxt1 >= SLOT_W);
   end

   always_ff @(posedge clk_i2s or posedge reset) begin
      if (reset) begin
         r_div  <= '0;
         r_sclk <= 1'b0;
      end else if (w_tc) begin
         r_div  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk_i2s or posedge reset) begin
      if (reset) begin
         r_pos      <= POS_LAST;
         r_data     <= 1'b0;
         r_lrclk    <= LEFT_JUSTIFIED;
         r_underrun <= 1'b0;
      end else begin
         r_underrun <= w_load & ~r_full;
         if (w_fall) begin
            r_pos   <= w_pos_nxt;
            r_data  <= w_data_nxt;
            r_lrclk <= w_lrclk_nxt;
         end
      end
   end

   always_ff @(posedge clk_i2s or posedge reset) begin
      if (reset) begin
         r_full    <= 1'b0;
         r_hold_l  <= '0;
         r_hold_r  <= '0;
         r_frame_l <= '0;
         r_frame_r <= '0;
      end else begin
         if (w_load) begin
            r_frame_l <= w_src_l;
            r_frame_r <= w_src_r;
         end
         if (w_accept) begin
            r_hold_l <= s_left;
            r_hold_r <= s_right;
         end
         // A pair accepted on an underrun load edge stays buffered.
         if (w_load && r_full) begin
            r_full <= 1'b0;
         end else if (w_accept) begin
            r_full <= 1'b1;
         end
      end
   end

   assign s_ready  = ~r_full;
   assign underrun = r_underrun;
   assign tx_mclk  = clk_i2s;
   assign tx_sclk  = r_sclk;
   assign tx_lrclk = r_lrclk;
   assign tx_data  = r_data;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx, I2S and left-justified
// instances driven from the same sample stream.
module tb_i2s_tx;

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
      logic        u;
   } frm_t;

   logic        clk_i2s;
   logic        reset;
   logic [23:0] s_left;
   logic [23:0] s_right;
   logic        s_valid;

   logic i_ready, i_und, i_mclk, i_sclk, i_lr, i_dat;
   logic j_ready, j_und, j_mclk, j_sclk, j_lr, j_dat;

   int   n_cmp = 0;
   int   n_err = 0;

   frm_t qf[$];
   int   rd[2];
   int   mpos[2];
   int   mcnt[2];
   int   mframes[2];
   logic mprev[2];
   frm_t cur[2];

   i2s_tx #(
      .MCLK_SCLK_RATIO(4),
      .SLOT_WIDTH(32),
      .DATA_WIDTH(24),
      .LEFT_JUSTIFIED(1'b0)
   ) u_i2s (
      .clk_i2s(clk_i2s),
      .reset(reset),
      .s_left(s_left),
      .s_right(s_right),
      .s_valid(s_valid),
      .s_ready(i_ready),
      .underrun(i_und),
      .tx_mclk(i_mclk),
      .tx_sclk(i_sclk),
      .tx_lrclk(i_lr),
      .tx_data(i_dat)
   );

   i2s_tx #(
      .MCLK_SCLK_RATIO(4),
      .SLOT_WIDTH(32),
      .DATA_WIDTH(24),
      .LEFT_JUSTIFIED(1'b1)
   ) u_lj (
      .clk_i2s(clk_i2s),
      .reset(reset),
      .s_left(s_left),
      .s_right(s_right),
      .s_valid(s_valid),
      .s_ready(j_ready),
      .underrun(j_und),
      .tx_mclk(j_mclk),
      .tx_sclk(j_sclk),
      .tx_lrclk(j_lr),
      .tx_data(j_dat)
   );

   initial clk_i2s = 1'b0;
   always #5 clk_i2s = ~clk_i2s;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic mon(input int id, input logic sclk, input logic dat,
                      input logic lr, input logic und, input bit lj);
      logic [23:0] w;
      int          k;
      logic        eb;
      logic        el;
      logic        eu;
      string       tag;
      tag = lj ? "lj" : "i2s";
      if (reset) begin
         mpos[id]  = 63;
         mprev[id] = 1'b0;
         mcnt[id]  = -1;
         rd[id]    = 0;
      end else begin
         mcnt[id]++;
         if (mprev[id] && !sclk) begin
            chk({tag, "_sclk_period"}, 32'(mcnt[id]), 32'd4);
            mcnt[id] = 0;
            mpos[id] = (mpos[id] == 63) ? 0 : mpos[id] + 1;
            if (mpos[id] == 0) begin
               if (rd[id] >= qf.size()) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL %s_frame: got frame expected none", tag);
                  cur[id] = '0;
               end else begin
                  cur[id] = qf[rd[id]];
                  rd[id]++;
               end
               mframes[id]++;
            end
            eu = (mpos[id] == 0) ? cur[id].u : 1'b0;
            chk({tag, "_underrun"}, 32'(und), 32'(eu));
            k  = mpos[id] % 32;
            w  = (mpos[id] >= 32) ? cur[id].r : cur[id].l;
            eb = (k < 24) ? w[23-k] : 1'b0;
            el = lj ? (mpos[id] >= 32) : (((mpos[id] + 1) % 64) >= 32);
            chk($sformatf("%s_data_p%0d", tag, mpos[id]),
                32'(dat), 32'(eb));
            chk($sformatf("%s_lrclk_p%0d", tag, mpos[id]),
                32'(lr), 32'(el));
         end
         mprev[id] = sclk;
      end
   endtask

   always @(negedge clk_i2s) begin
      mon(0, i_sclk, i_dat, i_lr, i_und, 1'b0);
      mon(1, j_sclk, j_dat, j_lr, j_und, 1'b1);
   end

   task automatic check_reset(input string nm);
      chk({nm, "_ready"}, 32'(i_ready), 32'd1);
      chk({nm, "_lj_ready"}, 32'(j_ready), 32'd1);
      chk({nm, "_sclk"}, 32'(i_sclk), 32'd0);
      chk({nm, "_lj_sclk"}, 32'(j_sclk), 32'd0);
      chk({nm, "_data"}, 32'(i_dat), 32'd0);
      chk({nm, "_lj_data"}, 32'(j_dat), 32'd0);
      chk({nm, "_lrclk"}, 32'(i_lr), 32'd0);
      chk({nm, "_lj_lrclk"}, 32'(j_lr), 32'd1);
      chk({nm, "_und"}, 32'(i_und), 32'd0);
      chk({nm, "_lj_und"}, 32'(j_und), 32'd0);
   endtask

   task automatic wait_frame(input int n);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk_i2s);
         #1;
         if (mframes[0] >= n) break;
      end
      if (mframes[0] < n) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_frame: got %0d expected %0d", mframes[0], n);
      end
   endtask

   task automatic send(input logic [23:0] l, input logic [23:0] r,
                       input string nm);
      bit ok;
      ok      = 1'b0;
      s_left  = l;
      s_right = r;
      s_valid = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (i_ready) begin
            @(posedge clk_i2s);
            #1;
            ok = 1'b1;
            break;
         end
         @(posedge clk_i2s);
         #1;
      end
      s_valid = 1'b0;
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s_accept: got none expected accept", nm);
      end else begin
         chk({nm, "_ready_drop"}, 32'(i_ready), 32'd0);
      end
   endtask

   initial begin
      logic [23:0] tl [4];
      logic [23:0] tr [4];
      bit found;
      tl = '{24'h000001, 24'h7FFFFF, 24'h123456, 24'hC3C3C3};
      tr = '{24'hFFFFFF, 24'h800000, 24'h654321, 24'h3C3C3C};
      mframes = '{0, 0};
      reset   = 1'b1;
      s_valid = 1'b0;
      s_left  = '0;
      s_right = '0;
      repeat (3) @(posedge clk_i2s);
      #1;
      check_reset("rst0");

      qf.push_back({24'h0, 24'h0, 1'b1});
      qf.push_back({24'h0, 24'h0, 1'b1});
      @(posedge clk_i2s);
      #1;
      reset = 1'b0;

      wait_frame(2);
      qf.push_back({24'hA50F3C, 24'h800001, 1'b0});
      send(24'hA50F3C, 24'h800001, "pairA");

      wait_frame(3);
      for (int j = 0; j < 4; j++) qf.push_back({tl[j], tr[j], 1'b0});
      qf.push_back({24'h0, 24'h0, 1'b1});
      for (int j = 0; j < 4; j++) send(tl[j], tr[j], $sformatf("strm%0d", j));

      wait_frame(8);
      qf.push_back({24'h0, 24'h0, 1'b1});
      qf.push_back({24'h5A5A5A, 24'hA5A5A5, 1'b0});
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk_i2s);
         #1;
         if (mpos[0] == 63) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_pos63: got none expected pos 63");
      end
      @(posedge clk_i2s);
      #1;
      @(posedge clk_i2s);
      #1;
      s_left  = 24'h5A5A5A;
      s_right = 24'hA5A5A5;
      s_valid = 1'b1;
      @(posedge clk_i2s);
      #1;
      s_valid = 1'b0;
      chk("load_edge_ready", 32'(i_ready), 32'd0);
      chk("load_edge_und", 32'(i_und), 32'd1);

      wait_frame(10);
      qf.push_back({24'h0F0F0F, 24'hF0F0F0, 1'b0});
      send(24'h0F0F0F, 24'hF0F0F0, "pairC");

      wait_frame(11);
      send(24'hDEAD01, 24'hBEEF02, "pairD");
      found = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk_i2s);
         #1;
         if (mpos[0] >= 40) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_pos40: got none expected pos 40");
      end
      reset = 1'b1;
      #1;
      check_reset("rst_mid");
      qf.delete();
      qf.push_back({24'h0, 24'h0, 1'b1});
      qf.push_back({24'h0, 24'h0, 1'b1});
      qf.push_back({24'h0, 24'h0, 1'b1});
      repeat (5) @(posedge clk_i2s);
      #1;
      reset = 1'b0;
      wait_frame(14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      n_cmp++;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
